// File: rtl/cdc_handshake_sync.sv
// Single-word clock-domain crossing: a toggle request/acknowledge handshake.
// The source holds the word in a register; the destination samples it only after the request toggle has crossed.
module cdc_handshake_sync #(
   parameter int DWIDTH     = 8,
   parameter int SYNC_STAGE = 2
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              clk_o,
   input  logic              rstn_o,
   input  logic              in_vld,
   input  logic [DWIDTH-1:0] din,
   output logic              in_ack,
   output logic              out_vld,
   output logic [DWIDTH-1:0] dout,
   input  logic              out_ack
);

   // ---------------- source domain (clk_i) ----------------
   logic [DWIDTH-1:0]     hold_q, hold_d;
   logic                  req_tgl_q, req_tgl_d;
   logic                  busy_q, busy_d;
   logic                  in_ack_q, in_ack_d;
   logic [SYNC_STAGE-1:0] ack_sync_q;

   // ---------------- destination domain (clk_o) -----------
   logic [SYNC_STAGE-1:0] req_sync_q;
   logic                  req_seen_q, req_seen_d;
   logic                  out_vld_q, out_vld_d;
   logic [DWIDTH-1:0]     dout_q, dout_d;
   logic                  ack_tgl_q, ack_tgl_d;

   logic accept;
   logic ack_synced;
   logic req_synced;
   logic req_edge;

   assign ack_synced = ack_sync_q[SYNC_STAGE-1];
   assign accept     = in_vld & ~busy_q & ~in_ack_q;

   always_comb begin
      hold_d    = hold_q;
      req_tgl_d = req_tgl_q;
      in_ack_d  = 1'b0;
      // Busy drops once the returned ack toggle matches the outstanding request.
      busy_d    = busy_q & (ack_synced != req_tgl_q);
      if (accept) begin
         hold_d    = din;
         req_tgl_d = ~req_tgl_q;
         in_ack_d  = 1'b1;
         busy_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         hold_q     <= '0;
         req_tgl_q  <= 1'b0;
         busy_q     <= 1'b0;
         in_ack_q   <= 1'b0;
         ack_sync_q <= '0;
      end else begin
         hold_q     <= hold_d;
         req_tgl_q  <= req_tgl_d;
         busy_q     <= busy_d;
         in_ack_q   <= in_ack_d;
         ack_sync_q <= {ack_sync_q[SYNC_STAGE-2:0], ack_tgl_q};
      end
   end

   assign req_synced = req_sync_q[SYNC_STAGE-1];
   assign req_edge   = req_synced != req_seen_q;

   // hold_q is frozen while the source is busy, so sampling it here is safe without a bus synchronizer.
   always_comb begin
      req_seen_d = req_seen_q;
      out_vld_d  = out_vld_q;
      dout_d     = dout_q;
      ack_tgl_d  = ack_tgl_q;
      if (req_edge) begin
         req_seen_d = req_synced;
         dout_d     = hold_q;
         out_vld_d  = 1'b1;
      end else if (out_vld_q && out_ack) begin
         out_vld_d = 1'b0;
         ack_tgl_d = ~ack_tgl_q;
      end
   end

   always_ff @(posedge clk_o or negedge rstn_o) begin
      if (!rstn_o) begin
         req_sync_q <= '0;
         req_seen_q <= 1'b0;
         out_vld_q  <= 1'b0;
         dout_q     <= '0;
         ack_tgl_q  <= 1'b0;
      end else begin
         req_sync_q <= {req_sync_q[SYNC_STAGE-2:0], req_tgl_q};
         req_seen_q <= req_seen_d;
         out_vld_q  <= out_vld_d;
         dout_q     <= dout_d;
         ack_tgl_q  <= ack_tgl_d;
      end
   end

   assign in_ack  = in_ack_q;
   assign out_vld = out_vld_q;
   assign dout    = dout_q;

endmodule

// File: tb/tb_cdc_handshake_sync.sv
// Scoreboard bench for cdc_handshake_sync: the source pushes expected words, and the sink pops them on each transfer.
// Delays are in tenths of a nanosecond so that a 1 ns clk_o period stays integral.
module tb_cdc_handshake_sync;

   logic       clk_i = 1'b0, clk_o = 1'b0;
   logic       rstn_i = 1'b0, rstn_o = 1'b0;
   logic       in_vld = 1'b0, out_ack = 1'b0;
   logic [7:0] din = 8'h00;
   logic       in_ack, out_vld;
   logic [7:0] dout;

   int half_i = 50;
   int half_o = 500;

   int         checks = 0, errors = 0;
   int         sent = 0, rcvd = 0;
   int         sink_mode = 0;   // 0 always ready, 1 random stalls, 2 never ready
   int         stall_cnt = 0;
   bit         held_vld = 1'b0;
   logic [7:0] held_dout = 8'h00;
   logic [7:0] exp_w;
   logic       prev_ack = 1'b0;
   logic [7:0] sb[$];

   cdc_handshake_sync #(.DWIDTH(8), .SYNC_STAGE(2)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .clk_o(clk_o), .rstn_o(rstn_o),
      .in_vld(in_vld), .din(din), .in_ack(in_ack),
      .out_vld(out_vld), .dout(dout), .out_ack(out_ack)
   );

   initial forever #(half_i) clk_i = ~clk_i;
   initial forever #(half_o) clk_o = ~clk_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] v, input int gap);
      int n;
      if (gap > 0) begin
         in_vld = 1'b0;
         repeat (gap) @(negedge clk_i);
      end
      sb.push_back(v);
      din    = v;
      in_vld = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!in_ack && n < 3000);
      checks++;
      if (!in_ack) begin
         errors++;
         $display("FAIL accept_timeout: word %0h in_ack=0 after %0d cycles, expected 1", v, n);
         void'(sb.pop_back());
      end else begin
         sent++;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || out_vld) && n < 6000) begin
         @(negedge clk_i);
         n++;
      end
      chk(name, sb.size(), 0);
   endtask

   // Sink: choose out_ack for the coming clk_o edge, then score the transfer it causes.
   initial forever begin
      @(negedge clk_o);
      if (!rstn_o) begin
         held_vld = 1'b0;
      end else begin
         if (held_vld) begin
            checks++;
            if (!out_vld || dout !== held_dout) begin
               errors++;
               $display("FAIL stall_hold: out_vld=%b dout=%0h expected out_vld=1 dout=%0h",
                        out_vld, dout, held_dout);
            end
         end
         case (sink_mode)
            0: out_ack = 1'b1;
            1: if (stall_cnt > 0) begin out_ack = 1'b0; stall_cnt--; end
               else out_ack = 1'b1;
            default: out_ack = 1'b0;
         endcase
         if (out_vld && out_ack) begin
            checks++;
            rcvd++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL extra_word: dout=%0h delivered with no word outstanding", dout);
            end else begin
               exp_w = sb.pop_front();
               if (dout !== exp_w) begin
                  errors++;
                  $display("FAIL dout: got %0h expected %0h", dout, exp_w);
               end
            end
            held_vld = 1'b0;
            if (sink_mode == 1) stall_cnt = $urandom_range(0, 7);
         end else begin
            held_vld  = out_vld;
            held_dout = dout;
         end
      end
   end

   // in_ack must be a single-cycle pulse.
   initial forever begin
      @(negedge clk_i);
      if (!rstn_i) prev_ack = 1'b0;
      else begin
         if (in_ack) begin
            checks++;
            if (prev_ack) begin
               errors++;
               $display("FAIL in_ack_pulse: in_ack=1 two cycles running, expected one");
            end
         end
         prev_ack = in_ack;
      end
   end

   initial begin
      #50000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   int gaps[10] = '{0, 1, 15, 7, 251, 0, 255, 3, 253, 1};
   int per_o[5] = '{150, 55, 45, 15, 5};
   int n;

   initial begin
      // reset
      repeat (3) @(negedge clk_i);
      chk("rst_in_ack", in_ack, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_dout", dout, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      rstn_o = 1'b1;
      repeat (5) @(negedge clk_o);
      chk("post_rst_out_vld", out_vld, 0);
      chk("post_rst_in_ack", in_ack, 0);
      chk("post_rst_dout", dout, 0);

      // slow sink, continuous source
      for (int i = 0; i < 100; i++) send(8'(i), 0);
      in_vld = 1'b0;
      drain("drain_slow_sink");

      // fast sinks
      for (int p = 0; p < 5; p++) begin
         half_o = per_o[p];
         for (int i = 0; i < 20; i++) send(8'(i), 0);
         in_vld = 1'b0;
         drain("drain_fast_sink");
      end

      // random sink stalls
      half_o = 70;
      sink_mode = 1;
      for (int i = 0; i < 30; i++) send(8'(8'hC0 + i), 0);
      in_vld = 1'b0;
      drain("drain_stall");
      sink_mode = 0;

      // source gaps
      for (int i = 0; i < 10; i++) send(8'(8'h30 + i), gaps[i]);
      in_vld = 1'b0;
      drain("drain_gaps");

      // reset with a word waiting at the sink
      half_o = 130;
      sink_mode = 2;
      send(8'hA5, 0);
      in_vld = 1'b0;
      n = 0;
      while (!out_vld && n < 3000) begin
         @(negedge clk_i);
         n++;
      end
      chk("pre_rst_out_vld", out_vld, 1);
      chk("pre_rst_dout", dout, 8'hA5);
      rstn_i = 1'b0;
      rstn_o = 1'b0;
      sb.delete();
      repeat (3) @(negedge clk_o);
      chk("mid_rst_out_vld", out_vld, 0);
      chk("mid_rst_in_ack", in_ack, 0);
      chk("mid_rst_dout", dout, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      rstn_o = 1'b1;
      sink_mode = 0;
      repeat (10) @(negedge clk_o);
      chk("no_spurious_out_vld", out_vld, 0);
      send(8'h5A, 0);
      in_vld = 1'b0;
      drain("drain_after_rst");
      // 100 + 5*20 + 30 + 10 + 1 words consumed; the 0xA5 word was dropped
      chk("rx_count", rcvd, 241);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
